// File: rtl/pll_reconfig_seq.sv
// Run-time PLL retuning sequencer: scans N/M/C divider settings into pllrcfg, triggers reconfig, waits for lock.
// Optional macro PLL_RETRY_EN: on lock timeout pulse pll_areset and retry up to MAX_RETRY times.
module pll_reconfig_seq #(
  parameter int unsigned FACTOR_W     = 8,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [FACTOR_W-1:0]        req_m,
  input  logic [FACTOR_W-1:0]        req_n,
  input  logic [NUM_CH*FACTOR_W-1:0] req_c,
  output logic                       done,
  output logic                       error,
  output logic                       stable,
  input  logic                       rc_busy,
  output logic                       rc_write_param,
  output logic [3:0]                 rc_counter_type,
  output logic [2:0]                 rc_counter_param,
  output logic [8:0]                 rc_data_in,
  output logic                       rc_reconfig,
  input  logic                       pll_locked,
  output logic                       pll_areset
);
  localparam int unsigned NUM_CNT = NUM_CH + 2;
  localparam int unsigned IDX_W   = $clog2(NUM_CNT);
  localparam int unsigned LOCK_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RTRY_W  = $clog2(MAX_RETRY + 2);
  localparam int unsigned FW1     = FACTOR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_WBUSY_H, S_WBUSY_L, S_RCFG, S_RBUSY_H, S_RBUSY_L, S_LOCK, S_ARESET
  } state_e;

  state_e                state_q, state_d;
  logic [FACTOR_W-1:0]   fac_q [NUM_CNT];
  logic [FACTOR_W-1:0]   fac_d [NUM_CNT];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            prm_q, prm_d;
  logic [3:0]            wait_q, wait_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                  lock_seen_q, lock_seen_d;
  logic [RTRY_W-1:0]     retry_q, retry_d;
  logic                  ready_q, ready_d, done_q, done_d, err_q, err_d, stable_q, stable_d;
  logic                  wp_q, wp_d, rcfg_q, rcfg_d, areset_q, areset_d;
  logic [3:0]            type_q, type_d;
  logic [2:0]            param_q, param_d;
  logic [8:0]            data_q, data_d;
  logic [FACTOR_W-1:0]   cur_f;
  logic                  any_zero, last_prm, last_cnt, adv, enter_lock;

  // Parameter slot order per counter: bypass, high, low, odd.
  function automatic logic [2:0] pcode(input logic [1:0] p);
    case (p)
      2'd0:    pcode = 3'b100;
      2'd1:    pcode = 3'b000;
      2'd2:    pcode = 3'b001;
      default: pcode = 3'b101;
    endcase
  endfunction

  function automatic logic [8:0] pval(input logic [FACTOR_W-1:0] f, input logic [1:0] p);
    logic [FACTOR_W:0] hi;
    hi = ({1'b0, f} + FW1'(1)) >> 1;
    case (p)
      2'd0:    pval = 9'(f == FACTOR_W'(1));
      2'd1:    pval = 9'(hi);
      2'd2:    pval = 9'(f >> 1);
      default: pval = 9'(f[0]);
    endcase
  endfunction

  function automatic logic [3:0] ctype(input logic [IDX_W-1:0] i);
    if (i < IDX_W'(2)) ctype = 4'(i);
    else               ctype = 4'(i) + 4'd2;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    fac_d       = fac_q;
    idx_d       = idx_q;
    prm_d       = prm_q;
    wait_d      = wait_q;
    lock_cnt_d  = lock_cnt_q;
    lock_seen_d = lock_seen_q;
    retry_d     = retry_q;
    type_d      = type_q;
    param_d     = param_q;
    data_d      = data_q;
    err_d       = err_q;
    done_d      = 1'b0;
    wp_d        = 1'b0;
    rcfg_d      = 1'b0;
    adv         = 1'b0;
    enter_lock  = 1'b0;
    cur_f       = fac_q[idx_q];
    last_prm    = (cur_f == FACTOR_W'(1)) || (prm_q == 2'd3);
    last_cnt    = (idx_q == IDX_W'(NUM_CNT - 1));
    any_zero    = (req_n == '0) || (req_m == '0);
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_c[i*FACTOR_W +: FACTOR_W] == '0) any_zero = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fac_d[0] = req_n;
          fac_d[1] = req_m;
          for (int i = 0; i < NUM_CH; i++) fac_d[i+2] = req_c[i*FACTOR_W +: FACTOR_W];
          retry_d = '0;
          err_d   = any_zero;
          if (!any_zero) begin
            idx_d   = '0;
            prm_d   = '0;
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        type_d  = ctype(idx_q);
        param_d = pcode(prm_q);
        data_d  = pval(cur_f, prm_q);
        wp_d    = 1'b1;
        wait_d  = '0;
        state_d = S_WBUSY_H;
      end
      S_WBUSY_H: begin
        if (rc_busy)                state_d = S_WBUSY_L;
        else if (wait_q == 4'd15)   adv = 1'b1;
        else                        wait_d = wait_q + 4'd1;
      end
      S_WBUSY_L: if (!rc_busy) adv = 1'b1;
      S_RCFG: begin
        rcfg_d  = 1'b1;
        wait_d  = '0;
        state_d = S_RBUSY_H;
      end
      S_RBUSY_H: begin
        if (rc_busy)                state_d = S_RBUSY_L;
        else if (wait_q == 4'd15)   enter_lock = 1'b1;
        else                        wait_d = wait_q + 4'd1;
      end
      S_RBUSY_L: if (!rc_busy) enter_lock = 1'b1;
      S_LOCK: begin
        lock_seen_d = pll_locked;
        lock_cnt_d  = lock_cnt_q + LOCK_W'(1);
        if (pll_locked && lock_seen_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (lock_cnt_q == LOCK_W'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_RETRY_EN
          if (retry_q == RTRY_W'(MAX_RETRY)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            retry_d = retry_q + RTRY_W'(1);
            wait_d  = '0;
            state_d = S_ARESET;
          end
`else
          err_d   = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
      S_ARESET: begin
        if (wait_q == 4'd3) enter_lock = 1'b1;
        else                wait_d = wait_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Step to the next parameter slot, then the next counter, then reconfig.
    if (adv) begin
      if (!last_prm) begin
        prm_d   = prm_q + 2'd1;
        state_d = S_WR;
      end else if (!last_cnt) begin
        idx_d   = idx_q + IDX_W'(1);
        prm_d   = '0;
        state_d = S_WR;
      end else begin
        state_d = S_RCFG;
      end
    end
    if (enter_lock) begin
      state_d     = S_LOCK;
      lock_cnt_d  = '0;
      lock_seen_d = 1'b0;
    end

    ready_d  = (state_d == S_IDLE);
    areset_d = (state_d == S_ARESET);
    stable_d = pll_locked && (state_d == S_IDLE) && !err_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_CNT; i++) fac_q[i] <= '0;
      idx_q       <= '0;
      prm_q       <= '0;
      wait_q      <= '0;
      lock_cnt_q  <= '0;
      lock_seen_q <= 1'b0;
      retry_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stable_q    <= 1'b0;
      wp_q        <= 1'b0;
      rcfg_q      <= 1'b0;
      areset_q    <= 1'b0;
      type_q      <= '0;
      param_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      fac_q       <= fac_d;
      idx_q       <= idx_d;
      prm_q       <= prm_d;
      wait_q      <= wait_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_seen_q <= lock_seen_d;
      retry_q     <= retry_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stable_q    <= stable_d;
      wp_q        <= wp_d;
      rcfg_q      <= rcfg_d;
      areset_q    <= areset_d;
      type_q      <= type_d;
      param_q     <= param_d;
      data_q      <= data_d;
    end
  end

  assign req_ready        = ready_q;
  assign done             = done_q;
  assign error            = err_q;
  assign stable           = stable_q;
  assign rc_write_param   = wp_q;
  assign rc_reconfig      = rcfg_q;
  assign rc_counter_type  = type_q;
  assign rc_counter_param = param_q;
  assign rc_data_in       = data_q;
  assign pll_areset       = areset_q;
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: pllrcfg/PLL responder plus a write-list reference model.
// Covers the PLL_RETRY_EN build when that macro is defined.
module tb_pll_reconfig_seq;
  localparam int unsigned FW  = 8;
  localparam int unsigned NCH = 2;
  localparam int unsigned TMO = 300;
  localparam int unsigned MR  = 2;

  logic            clock, reset_n, req_valid, req_ready, done, error, stable;
  logic [FW-1:0]   req_m, req_n;
  logic [NCH*FW-1:0] req_c;
  logic            rc_busy, rc_write_param, rc_reconfig, pll_locked, pll_areset;
  logic [3:0]      rc_counter_type;
  logic [2:0]      rc_counter_param;
  logic [8:0]      rc_data_in;

  pll_reconfig_seq #(.FACTOR_W(FW), .NUM_CH(NCH), .LOCK_TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_n(req_n), .req_c(req_c), .done(done), .error(error), .stable(stable),
    .rc_busy(rc_busy), .rc_write_param(rc_write_param), .rc_counter_type(rc_counter_type),
    .rc_counter_param(rc_counter_param), .rc_data_in(rc_data_in), .rc_reconfig(rc_reconfig),
    .pll_locked(pll_locked), .pll_areset(pll_areset)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur_word;
  int n_wp, n_rc, stab_err, rcfg_end_cyc, bursts, bad_burst, burst_len;
  int busy_len = 3;
  bit stuck_low = 0;
  int lock_mode = 1;   // 0 never locks, 1 locks shortly after reconfig, 2 locks after an areset burst

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // pllrcfg and PLL behavioural responder.
  initial begin
    int busy_left, relock;
    bit pend, pend_rcfg, prev_ar;
    rc_busy = 0; pll_locked = 0; busy_left = 0; relock = 0; pend = 0; pend_rcfg = 0; prev_ar = 0;
    n_wp = 0; n_rc = 0; stab_err = 0; rcfg_end_cyc = 0; bursts = 0; bad_burst = 0; burst_len = 0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) begin
        rc_busy = 0; busy_left = 0; pend = 0; pend_rcfg = 0; prev_ar = 0; burst_len = 0;
      end else begin
        if (rc_busy) begin
          if ({rc_counter_type, rc_counter_param, rc_data_in} !== cur_word && !pend_rcfg) stab_err++;
          busy_left--;
          if (busy_left == 0) begin
            rc_busy = 0;
            if (pend_rcfg) begin pend_rcfg = 0; rcfg_end_cyc = cyc; end
          end
        end else if (pend) begin
          pend = 0;
          if (!stuck_low) begin rc_busy = 1; busy_left = busy_len; end
          else pend_rcfg = 0;
        end
        if (rc_write_param) begin
          cur_word = {rc_counter_type, rc_counter_param, rc_data_in};
          wr_q.push_back(cur_word);
          n_wp++; pend = 1;
        end
        if (rc_reconfig) begin
          n_rc++; pend = 1; pend_rcfg = 1; pll_locked = 0; relock = 6;
        end
        if (relock > 0) begin
          relock--;
          if (relock == 0 && lock_mode == 1) pll_locked = 1;
        end
        if (pll_areset) burst_len++;
        if (prev_ar && !pll_areset) begin
          bursts++;
          if (burst_len != 4) bad_burst++;
          burst_len = 0;
          if (lock_mode == 2) pll_locked = 1;
        end
        prev_ar = pll_areset;
      end
    end
  end

  function automatic logic [15:0] word(input int unsigned t, input int unsigned p, input int unsigned d);
    return {4'(t), 3'(p), 9'(d)};
  endfunction

  // Expected write list from the factor rules: order N, M, C0, C1.
  function automatic void build_exp(input int unsigned f [4]);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      int unsigned t;
      t = (i < 2) ? i : 4 + (i - 2);
      if (f[i] == 1) exp_q.push_back(word(t, 4, 1));
      else begin
        exp_q.push_back(word(t, 4, 0));
        exp_q.push_back(word(t, 0, (f[i] + 1) / 2));
        exp_q.push_back(word(t, 1, f[i] / 2));
        exp_q.push_back(word(t, 5, f[i] % 2));
      end
    end
  endfunction

  function automatic int wr_diff();
    int d = 0;
    if (wr_q.size() != exp_q.size()) d++;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic send(input int unsigned f [4]);
    int k = 0;
    while (req_ready !== 1'b1 && k < 3000) begin @(posedge clock); #1; k++; end
    checks++;
    if (k >= 3000) begin errors++; $display("FAIL send_ready: req_ready=%b, required 1", req_ready); end
    req_n = FW'(f[0]); req_m = FW'(f[1]); req_c = {FW'(f[3]), FW'(f[2])}; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_end(output bit d, output bit e, output int at);
    d = 0; e = 0; at = 0;
    for (int k = 0; k < 6000; k++) begin
      if (done === 1'b1) begin d = 1; at = cyc; break; end
      if (error === 1'b1) begin e = 1; at = cyc; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic run_seq(input int unsigned f [4], output bit d, output bit e, output int at);
    wr_q.delete(); n_wp = 0; n_rc = 0; stab_err = 0; bursts = 0; bad_burst = 0;
    build_exp(f);
    send(f);
    wait_end(d, e, at);
  endtask

  task automatic chk_reset_vals(input string tag);
    checks++;
    if ({req_ready, done, error, rc_write_param, rc_reconfig, pll_areset} !== 6'b100000) begin
      errors++;
      $display("FAIL %s_strobes: ready/done/err/wp/rcfg/ar=%b, required 100000", tag,
               {req_ready, done, error, rc_write_param, rc_reconfig, pll_areset});
    end
    checks++;
    if ({rc_counter_type, rc_counter_param, rc_data_in} !== 16'h0) begin
      errors++;
      $display("FAIL %s_bus: type/param/data=%h, required 0000", tag,
               {rc_counter_type, rc_counter_param, rc_data_in});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    checks++;
    if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b, required 0", stable); end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    int unsigned f [4] = '{1, 4, 3, 2};
    bit d, e; int at;
    busy_len = 3; stuck_low = 0; lock_mode = 1;
    run_seq(f, d, e, at);
    checks++;
    if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL directed_done: done=%b err=%b, required 1/0", d, e); end
    checks++;
    if (wr_diff() != 0) begin
      errors++; $display("FAIL directed_writes: %0d writes, %0d diffs, required %0d writes 0 diffs", wr_q.size(), wr_diff(), exp_q.size());
    end
    checks++;
    if (n_rc != 1) begin errors++; $display("FAIL directed_reconfig: %0d strobes, required 1", n_rc); end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL directed_stable_bus: %0d changes while busy, required 0", stab_err); end
    repeat (2) begin @(posedge clock); #1; end
    checks++;
    if (stable !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL directed_idle: stable=%b ready=%b, required 1/1", stable, req_ready);
    end
  endtask

  task automatic test_zero_factor();
    int unsigned fz [4] = '{3, 5, 0, 2};
    int unsigned fg [4] = '{2, 3, 1, 7};
    bit d, e; int at;
    wr_q.delete(); n_wp = 0;
    send(fz);
    checks++;
    if (error !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL zero_error: error=%b ready=%b, required 1/1", error, req_ready);
    end
    repeat (5) begin @(posedge clock); #1; end
    checks++;
    if (n_wp != 0 || error !== 1'b1) begin
      errors++; $display("FAIL zero_nowrite: writes=%0d error=%b, required 0/1", n_wp, error);
    end
    wr_q.delete(); n_wp = 0; n_rc = 0;
    build_exp(fg);
    send(fg);
    checks++;
    if (error !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL zero_clear: error=%b ready=%b, required 0/0", error, req_ready);
    end
    wait_end(d, e, at);
    checks++;
    if (d !== 1'b1 || wr_diff() != 0) begin
      errors++; $display("FAIL zero_recover: done=%b diffs=%0d, required 1/0", d, wr_diff());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int unsigned f [4];
      bit d, e; int at;
      for (int j = 0; j < 4; j++)
        f[j] = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 255);
      busy_len = $urandom_range(1, 5);
      run_seq(f, d, e, at);
      checks++;
      if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL rand%0d_done: done=%b err=%b, required 1/0", it, d, e); end
      checks++;
      if (wr_diff() != 0) begin
        errors++; $display("FAIL rand%0d_writes: %0d writes %0d diffs, required %0d writes 0 diffs", it, wr_q.size(), wr_diff(), exp_q.size());
      end
      checks++;
      if (n_rc != 1) begin errors++; $display("FAIL rand%0d_reconfig: %0d, required 1", it, n_rc); end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL rand%0d_stable_bus: %0d, required 0", it, stab_err); end
    end
  endtask

  task automatic test_ignore_busy();
    int unsigned f [4] = '{6, 9, 1, 4};
    bit d, e; int at; int k = 0;
    busy_len = 2;
    wr_q.delete(); n_wp = 0; n_rc = 0;
    build_exp(f);
    send(f);
    while (n_wp < 2 && k < 500) begin @(posedge clock); #1; k++; end
    req_m = '0; req_n = 8'd3; req_c = '0; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_end(d, e, at);
    checks++;
    if (d !== 1'b1 || e !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL ignore_done: done=%b err=%b, required 1/0", d, e);
    end
    checks++;
    if (wr_diff() != 0) begin errors++; $display("FAIL ignore_writes: %0d diffs, required 0", wr_diff()); end
  endtask

  task automatic test_busy_stuck();
    int unsigned f [4] = '{2, 5, 1, 3};
    bit d, e; int at;
    stuck_low = 1;
    run_seq(f, d, e, at);
    stuck_low = 0;
    checks++;
    if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL stuck_done: done=%b err=%b, required 1/0", d, e); end
    checks++;
    if (wr_diff() != 0 || n_rc != 1) begin
      errors++; $display("FAIL stuck_writes: diffs=%0d reconfig=%0d, required 0/1", wr_diff(), n_rc);
    end
  endtask

  task automatic test_mid_reset();
    int unsigned f  [4] = '{4, 7, 5, 6};
    int unsigned f2 [4] = '{3, 2, 9, 1};
    bit d, e; int at; int k = 0;
    busy_len = 4;
    wr_q.delete(); n_wp = 0;
    send(f);
    while (!(rc_busy === 1'b1 && n_wp >= 3) && k < 500) begin @(posedge clock); #1; k++; end
    @(posedge clock); #1;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    run_seq(f2, d, e, at);
    checks++;
    if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL midreset_done: done=%b err=%b, required 1/0", d, e); end
    checks++;
    if (wr_diff() != 0) begin errors++; $display("FAIL midreset_writes: %0d diffs, required 0", wr_diff()); end
  endtask

`ifdef PLL_RETRY_EN
  task automatic test_retry();
    int unsigned f [4] = '{2, 3, 4, 1};
    bit d, e; int at;
    busy_len = 2;
    lock_mode = 2;
    run_seq(f, d, e, at);
    checks++;
    if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL retry_ok_done: done=%b err=%b, required 1/0", d, e); end
    checks++;
    if (bursts != 1 || bad_burst != 0) begin
      errors++; $display("FAIL retry_ok_bursts: %0d bursts %0d bad, required 1/0", bursts, bad_burst);
    end
    lock_mode = 0;
    run_seq(f, d, e, at);
    repeat (3) begin @(posedge clock); #1; end
    checks++;
    if (e !== 1'b1 || d !== 1'b0 || error !== 1'b1) begin
      errors++; $display("FAIL retry_fail_err: done=%b err=%b, required 0/1", d, e);
    end
    checks++;
    if (bursts != 2 || bad_burst != 0) begin
      errors++; $display("FAIL retry_fail_bursts: %0d bursts %0d bad, required 2/0", bursts, bad_burst);
    end
  endtask
`else
  task automatic test_timeout();
    int unsigned f [4] = '{1, 2, 3, 4};
    bit d, e; int at;
    busy_len = 2;
    lock_mode = 0;
    run_seq(f, d, e, at);
    checks++;
    if (e !== 1'b1 || d !== 1'b0) begin errors++; $display("FAIL timeout_err: done=%b err=%b, required 0/1", d, e); end
    checks++;
    if (at - rcfg_end_cyc != int'(TMO) + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles, required %0d", at - rcfg_end_cyc, TMO + 1);
    end
    repeat (3) begin @(posedge clock); #1; end
    checks++;
    if (bursts != 0 || pll_areset !== 1'b0) begin
      errors++; $display("FAIL timeout_areset: bursts=%0d areset=%b, required 0/0", bursts, pll_areset);
    end
    checks++;
    if (error !== 1'b1 || stable !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: error=%b stable=%b ready=%b, required 1/0/1", error, stable, req_ready);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_m = '0; req_n = '0; req_c = '0;
    test_reset();
    test_directed();
    test_zero_factor();
    test_random();
    test_ignore_busy();
    test_busy_stuck();
    test_mid_reset();
`ifdef PLL_RETRY_EN
    test_retry();
`else
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
